// File: rtl/param_table_arbiter.sv
// param_table_arbiter
//
// Shared lookup-table controller. The table is a register array loaded from
// INIT on reset. Four requesters share one read port under round-robin
// arbitration, and a configuration port can overwrite entries at run time.
// At most one access, either a read or a write, happens per cycle. A write
// always wins over reads.
//
// Handshake: req[k] is a level-sampled request with no ready or back-pressure.
// A cycle's request is accepted at edge t only when cfg_we is low and requester
// k is the round-robin winner. Acceptance is reported after edge t by a
// one-cycle pulse on grant[k], which equals rsp_valid[k]. rsp_data carries the
// read value in that same cycle. A requester that is not served keeps req high.
// When it is served, it may drop req or hold it to issue another request.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        per-requester read request
//   req_addr   requester k address in bits [k*AW +: AW]
//   cfg_we     table write enable (takes priority over reads)
//   cfg_addr   write address
//   cfg_data   write data
//   grant      registered one-hot grant (zero when no read was served)
//   rsp_valid  registered response strobe, identical to grant
//   rsp_data   registered read data (zero when nothing served or out of range)

module param_table_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter logic [WIDTH-1:0] INIT [DEPTH] = '{
        8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88
    }
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [4*AW-1:0]  req_addr,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    output logic [3:0]       grant,
    output logic [3:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_data
);

    // Table storage and arbitration state.
    logic [WIDTH-1:0] table_q [DEPTH];
    logic [1:0]       last_q;
    logic [3:0]       grant_q;
    logic [WIDTH-1:0] rsp_data_q;

    // Combinational arbitration results.
    logic             any_req;
    logic [1:0]       winner;
    logic [3:0]       winner_onehot;
    logic [AW-1:0]    rd_addr;
    logic             rd_in_range;
    logic             wr_in_range;
    logic [WIDTH-1:0] rd_value;

    assign any_req = |req;

    // Round-robin search. The candidates are scanned in the order last+1,
    // last+2, last+3, last. The 2-bit sum wraps modulo 4 on its own. The scan
    // runs from the farthest candidate down to the nearest, so the nearest
    // requesting candidate is written last and wins.
    always_comb begin
        logic [1:0] cand;
        winner = last_q;
        for (int i = 3; i >= 0; i--) begin
            cand = last_q + 2'(i + 1);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        winner_onehot         = 4'b0000;
        winner_onehot[winner] = 1'b1;
    end

    // The winner's address is selected by indexing into the packed bus.
    assign rd_addr = req_addr[winner*AW +: AW];

    // Range checks use one extra bit so the comparison also works when DEPTH
    // is an exact power of two (every address valid) or is 1.
    assign rd_in_range = ({1'b0, rd_addr}  < (AW+1)'(DEPTH));
    assign wr_in_range = ({1'b0, cfg_addr} < (AW+1)'(DEPTH));

    // An out-of-range read returns zero and never indexes past the array.
    always_comb begin
        rd_value = '0;
        if (rd_in_range) begin
            rd_value = table_q[rd_addr];
        end
    end

    // Storage, pointer and response registers. One block holds them all so
    // that the write/read exclusivity is visible in a single place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= INIT[i];
            end
            last_q     <= 2'd3;
            grant_q    <= 4'b0000;
            rsp_data_q <= '0;
        end else if (cfg_we) begin
            // The write owns the cycle. Pending reads wait and last_q holds.
            // An out-of-range write is dropped.
            if (wr_in_range) begin
                table_q[cfg_addr] <= cfg_data;
            end
            grant_q    <= 4'b0000;
            rsp_data_q <= '0;
        end else if (any_req) begin
            grant_q    <= winner_onehot;
            rsp_data_q <= rd_value;
            last_q     <= winner;
        end else begin
            grant_q    <= 4'b0000;
            rsp_data_q <= '0;
        end
    end

    assign grant     = grant_q;
    assign rsp_valid = grant_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: doc/param_table_arbiter.md
# param_table_arbiter

Shared lookup-table controller: holds a parameter-initialised unpacked logic array and arbitrates its single read port among four requesters with round-robin fairness. A configuration write port overlays new values onto the table at run time. It sits between constant-table consumers and the table storage, sequencing every access; the table never has more than one reader or writer per cycle.

## Interface
- WIDTH, 8: bits per table entry.
- DEPTH, 8: number of entries; AW = max(1, $clog2(DEPTH)).
- INIT, entry i = 8'h11*(i+1) (8'h11, 8'h22, … 8'h88): unpacked `logic [WIDTH-1:0] INIT [DEPTH]`, reset contents of the table.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-requester read request, sampled every cycle.
- req_addr  input  4*AW  requester k address in bits [k*AW +: AW].
- cfg_we  input  1  table write enable.
- cfg_addr  input  AW  write address.
- cfg_data  input  WIDTH  write data.
- grant  output  4  registered one-hot grant, marks the served requester.
- rsp_valid  output  4  registered one-hot response strobe, equal to grant.
- rsp_data  output  WIDTH  registered read data for the granted requester.

## Operation
- Storage: DEPTH×WIDTH registers loaded from INIT on reset.
- Round-robin pointer `last` (2 bits) records the last granted requester. Reset value is 3, so requester 0 has top priority first.
- Each cycle, when cfg_we=0 and req≠0, the winner is the first requester with req=1 in the order last+1, last+2, last+3, last (mod 4).
  - At the next edge: grant and rsp_valid take the winner one-hot, rsp_data = table[req_addr of winner], and last is set to the winner.
- Write priority: when cfg_we=1, table[cfg_addr] ← cfg_data at the edge. No read is granted that cycle (grant, rsp_valid and rsp_data go to 0), and last is unchanged. Requesters keep req asserted and are served in a later cycle.
- One transaction per cycle. A requester that holds req high after being served issues a new request and competes normally. Under contention it waits behind the others.
- Out-of-range address (≥ DEPTH):
  - A read returns rsp_data = 0 with rsp_valid still asserted.
  - A write is discarded.
- When req=0 and cfg_we=0, the next cycle has grant=0, rsp_valid=0 and rsp_data=0.

## Timing
- Reset (async, immediate): grant=0, rsp_valid=0, rsp_data=0, last=3, table=INIT.
  - Reset mid-operation drops any pending response and discards all prior cfg writes.
- Read latency: 1 cycle. Request and address are sampled at edge t; grant, rsp_valid and rsp_data are valid after edge t.
- Write latency: 1 cycle. A read in the cycle after a write returns the written value; no bypass is needed, because a read cannot coincide with a write.
- grant and rsp_valid are identical, one-hot or zero, and never multi-hot.
- Fairness: with all four requesting continuously and no writes, each requester is granted exactly once in every 4 consecutive cycles.

## Test plan
- Reset, then req=0001 with addr0=3 for one cycle -> next cycle grant=0001, rsp_valid=0001, rsp_data=8'h44. The following cycle all outputs are 0.
- req=1111 held for 5 cycles, all addresses 0 -> grants 0001, 0010, 0100, 1000, 0001; rsp_data=8'h11 each cycle.
- cfg_we=1, cfg_addr=2, cfg_data=8'hA5 while req=0100 with addr2=2:
  - that cycle -> grant=0;
  - next cycle -> grant=0100, rsp_data=8'hA5.
- After the write above, pulse rst mid-stream with req=1111 -> outputs 0 immediately. After release, the first grant is 0001, and a read of entry 2 returns 8'h33.
- last=0 (after a grant to requester 0), then req=1010 held -> grant 0010, then 1000, then 0010.
- DEPTH=6 override, req=0001 with addr0=7 -> rsp_valid=0001, rsp_data=0. A cfg write to addr 7 leaves entries 0–5 unchanged.
